// File: rtl/pbus_pkg.sv
// Purpose : shared definitions for the two-master physical-bus arbiter.
// Latency : n/a (types, constants and one helper function only).
// Backpressure: n/a.
package pbus_pkg;

    // Arbiter state encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } pbus_state_e;

    // Error causes reported on err_code while err is high.
    localparam logic [15:0] PBUS_ERR_TIMEOUT = 16'd1;
    localparam logic [15:0] PBUS_ERR_STROBE  = 16'd2;

    // Owner selection when leaving IDLE. With both masters requesting,
    // round-robin hands the bus to whichever master was not served last;
    // fixed priority always picks master 0.
    function automatic logic pick_owner(
        input logic req0,
        input logic req1,
        input logic last,
        input logic rr_en
    );
        if (req0 && req1) begin
            return rr_en ? ~last : 1'b0;
        end
        return req0 ? 1'b0 : 1'b1;
    endfunction

endpackage

// File: rtl/pbus_timeout.sv
// Purpose : 16-bit down-counter that flags a stalled bus transaction.
// Latency : expired rises load_val+1 cycles after the load cycle.
// Backpressure: none; load/clear are accepted every cycle, clear wins.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   load       arm the counter with load_val
//   clear      disarm and zero the counter
//   load_val   reload value (cycles-to-expiry minus one)
//   expired    armed counter has reached zero
module pbus_timeout (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [15:0] load_val,
    output logic        expired
);

    logic [15:0] cnt_q, cnt_d;
    logic        armed_q, armed_d;

    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (clear) begin
            cnt_d   = '0;
            armed_d = 1'b0;
        end else if (load) begin
            cnt_d   = load_val;
            armed_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    // A zero count only means something once the counter has been armed;
    // it stays asserted until the owner of the counter clears it.
    assign expired = armed_q && (cnt_q == '0);

endmodule

// File: rtl/pbus_arb2.sv
// Purpose : merges two MMU physical ports onto one req/gnt/hrd/ready bus port.
// Latency : 1 cycle request->gnt, 0 cycles strobe->pwe/prd and pready->mXready.
// Backpressure: phrd blocks new ownership; pgnt low holds a strobe off; a
//               stalled transaction is aborted after TIMEOUT_CYCLES.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   m0req/m1req                    master wants ownership (level)
//   m0gnt/m1gnt, m0hrd/m1hrd       master owns the bus / must not start
//   m0a,m0d,m0we,m0rd (and m1*)    address, write data, one-cycle strobes
//   m0spo/m1spo, m0ready/m1ready   read data and completion to the owner
//   preq, pgnt, phrd               slave-side request, grant, hold
//   pa, pd, pwe, prd               owner address/data/strobes to the slave
//   pspo, pready                   slave read data and completion
//   err, err_code                  one-cycle error pulse and its cause
// Build option: define PBUS_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise master 0 has fixed priority.
module pbus_arb2
    import pbus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0req,
    input  logic        m1req,
    output logic        m0gnt,
    output logic        m1gnt,
    output logic        m0hrd,
    output logic        m1hrd,
    input  logic [31:0] m0a,
    input  logic [31:0] m0d,
    input  logic [31:0] m1a,
    input  logic [31:0] m1d,
    input  logic        m0we,
    input  logic        m0rd,
    input  logic        m1we,
    input  logic        m1rd,
    output logic [31:0] m0spo,
    output logic [31:0] m1spo,
    output logic        m0ready,
    output logic        m1ready,
    output logic        preq,
    input  logic        pgnt,
    input  logic        phrd,
    output logic [31:0] pa,
    output logic [31:0] pd,
    output logic        pwe,
    output logic        prd,
    input  logic [31:0] pspo,
    input  logic        pready,
    output logic        err,
    output logic [15:0] err_code
);

`ifdef PBUS_ARB_ROUND_ROBIN_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    // The counter is loaded on the strobe cycle and first counts in the
    // following cycle, so it expires exactly TIMEOUT_CYCLES after the strobe.
    localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);

    pbus_state_e state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q,  last_d;

    logic        own_req, own_we, own_rd;
    logic        granted;
    logic        fwd;        // owner strobe goes to the slave this cycle
    logic        cpl;        // transaction finishes this cycle
    logic [31:0] cpl_dat;
    logic        tmo_load, tmo_clear, tmo_expired;

    assign own_req = owner_q ? m1req : m0req;
    assign own_we  = owner_q ? m1we  : m0we;
    assign own_rd  = owner_q ? m1rd  : m0rd;
    assign granted = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        fwd       = 1'b0;
        cpl       = 1'b0;
        cpl_dat   = '0;
        tmo_load  = 1'b0;
        tmo_clear = 1'b0;
        err       = 1'b0;
        err_code  = '0;
        case (state_q)
            IDLE: begin
                if (!phrd && (m0req || m1req)) begin
                    owner_d = pick_owner(m0req, m1req, last_q, RR_EN);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (own_we && own_rd) begin
                    err      = 1'b1;
                    err_code = PBUS_ERR_STROBE;
                end else if ((own_we || own_rd) && pgnt) begin
                    fwd      = 1'b1;
                    tmo_load = 1'b1;
                    state_d  = BUSY;
                end else if (!own_req && !own_we && !own_rd) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            BUSY: begin
                // pready is checked first so a completion on the expiry
                // cycle is delivered normally without an error.
                if (pready) begin
                    cpl       = 1'b1;
                    cpl_dat   = pspo;
                    tmo_clear = 1'b1;
                    state_d   = GRANT;
                end else if (tmo_expired) begin
                    cpl       = 1'b1;
                    err       = 1'b1;
                    err_code  = PBUS_ERR_TIMEOUT;
                    tmo_clear = 1'b1;
                    state_d   = GRANT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    pbus_timeout u_timeout (
        .clk      (clk),
        .rst      (rst),
        .load     (tmo_load),
        .clear    (tmo_clear),
        .load_val (TMO_LOAD),
        .expired  (tmo_expired)
    );

    assign m0gnt = granted & ~owner_q;
    assign m1gnt = granted &  owner_q;
    assign preq  = granted;

    assign m0hrd = phrd | (granted &  owner_q);
    assign m1hrd = phrd | (granted & ~owner_q);

    // Master 0 drives the slave address/data while the bus is unowned.
    assign pa  = (granted & owner_q) ? m1a : m0a;
    assign pd  = (granted & owner_q) ? m1d : m0d;
    assign pwe = fwd & own_we;
    assign prd = fwd & own_rd;

    assign m0ready = cpl & ~owner_q;
    assign m1ready = cpl &  owner_q;
    assign m0spo   = (cpl & ~owner_q) ? cpl_dat : 32'd0;
    assign m1spo   = (cpl &  owner_q) ? cpl_dat : 32'd0;

endmodule

// File: tb/tb_pbus_arb2.sv
module tb_pbus_arb2;

    localparam int T = 4;
`ifdef PBUS_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  mreq, mwe, mrd;
    logic [31:0] ma [2];
    logic [31:0] md [2];
    logic        pgnt, phrd, pready;
    logic [31:0] pspo;

    logic [1:0]  gnt, hrd, rdy;
    logic [31:0] spo0, spo1, pa, pd;
    logic        preq, pwe, prd, err;
    logic [15:0] err_code;

    int n_pass  = 0;
    int n_total = 0;

    // Transaction-level reference: who owns the bus (-1 = nobody), whether a
    // transfer is outstanding, how many cycles since it was forwarded, and
    // which master released the bus most recently.
    int m_own  = -1;
    bit m_busy = 1'b0;
    int m_age  = 0;
    int m_last = 1;

    pbus_arb2 #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .m0req(mreq[0]), .m1req(mreq[1]),
        .m0gnt(gnt[0]), .m1gnt(gnt[1]),
        .m0hrd(hrd[0]), .m1hrd(hrd[1]),
        .m0a(ma[0]), .m0d(md[0]), .m1a(ma[1]), .m1d(md[1]),
        .m0we(mwe[0]), .m0rd(mrd[0]), .m1we(mwe[1]), .m1rd(mrd[1]),
        .m0spo(spo0), .m1spo(spo1),
        .m0ready(rdy[0]), .m1ready(rdy[1]),
        .preq(preq), .pgnt(pgnt), .phrd(phrd),
        .pa(pa), .pd(pd), .pwe(pwe), .prd(prd),
        .pspo(pspo), .pready(pready),
        .err(err), .err_code(err_code)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock: compare every output with the reference, then advance it.
    task automatic tick();
        logic [1:0]  e_gnt, e_hrd, e_rdy;
        logic [31:0] e_spo [2];
        logic [31:0] e_pa, e_pd;
        logic        e_pwe, e_prd, e_err;
        logic [15:0] e_code;
        int          n_own, n_age, n_last;
        bit          n_busy;
        logic        we, rd;
        #1;
        n_own = m_own; n_busy = m_busy; n_age = m_age; n_last = m_last;
        e_rdy = 2'b00; e_spo[0] = 32'd0; e_spo[1] = 32'd0;
        e_pwe = 1'b0; e_prd = 1'b0; e_err = 1'b0; e_code = 16'd0;
        for (int i = 0; i < 2; i++) begin
            e_gnt[i] = (m_own == i);
            e_hrd[i] = phrd || (m_own >= 0 && m_own != i);
        end
        e_pa = (m_own >= 0) ? ma[m_own] : ma[0];
        e_pd = (m_own >= 0) ? md[m_own] : md[0];
        if (m_own < 0) begin
            if (!phrd && (mreq[0] || mreq[1])) begin
                if (mreq[0] && mreq[1]) n_own = RR ? 1 - m_last : 0;
                else                    n_own = mreq[0] ? 0 : 1;
            end
        end else if (!m_busy) begin
            we = mwe[m_own]; rd = mrd[m_own];
            if (we && rd) begin
                e_err = 1'b1; e_code = 16'd2;
            end else if ((we || rd) && pgnt) begin
                e_pwe = we; e_prd = rd; n_busy = 1'b1; n_age = 1;
            end else if (!mreq[m_own] && !we && !rd) begin
                n_own = -1; n_last = m_own;
            end
        end else begin
            if (pready) begin
                e_rdy[m_own] = 1'b1; e_spo[m_own] = pspo; n_busy = 1'b0;
            end else if (m_age >= T) begin
                e_rdy[m_own] = 1'b1; e_err = 1'b1; e_code = 16'd1; n_busy = 1'b0;
            end else begin
                n_age = m_age + 1;
            end
        end
        if (rst) begin
            n_own = -1; n_busy = 1'b0; n_age = 0; n_last = 1;
        end
        chk("gnt", {30'd0, gnt}, {30'd0, e_gnt});
        chk("hrd", {30'd0, hrd}, {30'd0, e_hrd});
        chk("ready", {30'd0, rdy}, {30'd0, e_rdy});
        chk("spo0", spo0, e_spo[0]);
        chk("spo1", spo1, e_spo[1]);
        chk("preq", {31'd0, preq}, {31'd0, (m_own >= 0)});
        chk("pa", pa, e_pa);
        chk("pd", pd, e_pd);
        chk("pwe", {31'd0, pwe}, {31'd0, e_pwe});
        chk("prd", {31'd0, prd}, {31'd0, e_prd});
        chk("err", {31'd0, err}, {31'd0, e_err});
        chk("err_code", {16'd0, err_code}, {16'd0, e_code});
        @(posedge clk);
        m_own = n_own; m_busy = n_busy; m_age = n_age; m_last = n_last;
        @(negedge clk);
    endtask

    initial begin
        int winner;
        int w;
        rst = 1'b1; mreq = '0; mwe = '0; mrd = '0;
        ma[0] = '0; ma[1] = '0; md[0] = '0; md[1] = '0;
        pgnt = 1'b0; phrd = 1'b0; pready = 1'b0; pspo = '0;
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;

        // Reset values; holds follow phrd alone.
        #1;
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_preq", {31'd0, preq}, 32'd0);
        chk("rst_err_code", {16'd0, err_code}, 32'd0);
        phrd = 1'b1; #1;
        chk("rst_hrd_phrd", {30'd0, hrd}, 32'd3);
        phrd = 1'b0;
        tick();

        // Single read from master 0.
        mreq[0] = 1'b1; md[0] = 32'h1234_5678; ma[1] = 32'hAAAA_0000;
        tick();
        #1;
        chk("t1_gnt_cycle1", {30'd0, gnt}, 32'd1);
        chk("t1_m1hrd", {31'd0, hrd[1]}, 32'd1);
        ma[0] = 32'h8000_0010; mrd[0] = 1'b1; pgnt = 1'b1; #1;
        chk("t1_prd_same_cycle", {31'd0, prd}, 32'd1);
        chk("t1_pa", pa, 32'h8000_0010);
        tick();
        mrd[0] = 1'b0; pgnt = 1'b0;
        tick(); tick();
        pready = 1'b1; pspo = 32'hDEAD_BEEF; #1;
        chk("t1_m0ready", {31'd0, rdy[0]}, 32'd1);
        chk("t1_m0spo", spo0, 32'hDEAD_BEEF);
        chk("t1_m1hrd_end", {31'd0, hrd[1]}, 32'd1);
        tick();
        pready = 1'b0;

        // Timeout: strobe forwarded, pready never comes.
        mwe[0] = 1'b1; md[0] = $urandom; pgnt = 1'b1;
        tick();
        mwe[0] = 1'b0; pgnt = 1'b0;
        repeat (T - 1) tick();
        #1;
        chk("tmo_err", {31'd0, err}, 32'd1);
        chk("tmo_code", {16'd0, err_code}, 32'd1);
        chk("tmo_ready", {30'd0, rdy}, 32'd1);
        chk("tmo_spo_zero", spo0, 32'd0);
        tick();
        #1;
        chk("tmo_back_grant", {30'd0, gnt}, 32'd1);

        // Write and read strobed together.
        mwe[0] = 1'b1; mrd[0] = 1'b1; pgnt = 1'b1; #1;
        chk("dual_pwe", {31'd0, pwe}, 32'd0);
        chk("dual_prd", {31'd0, prd}, 32'd0);
        chk("dual_code", {16'd0, err_code}, 32'd2);
        tick();
        mwe[0] = 1'b0; mrd[0] = 1'b0; pgnt = 1'b0; #1;
        chk("dual_stay_grant", {30'd0, gnt}, 32'd1);
        mreq[0] = 1'b0;
        tick();

        // phrd blocks a new grant until it falls.
        phrd = 1'b1; mreq[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1; chk("hold_no_gnt", {30'd0, gnt}, 32'd0);
            tick();
        end
        phrd = 1'b0;
        tick();
        #1; chk("hold_gnt_after", {30'd0, gnt}, 32'd2);
        mreq[1] = 1'b0;
        tick();

        // Both masters competing, each doing one write per ownership.
        mreq = 2'b11;
        tick();
        for (int r = 0; r < 4; r++) begin
            #1;
            winner = (gnt == 2'b01) ? 0 : (gnt == 2'b10) ? 1 : -1;
            chk("arb_winner", winner, RR ? (r % 2) : 0);
            w = (winner < 0) ? 0 : winner;
            mwe[w] = 1'b1; ma[w] = $urandom; md[w] = $urandom; pgnt = 1'b1;
            tick();
            mwe[w] = 1'b0; pgnt = 1'b0;
            pready = 1'b1; pspo = $urandom;
            tick();
            pready = 1'b0; mreq[w] = 1'b0;
            tick();
            mreq[w] = 1'b1;
            tick();
        end
        mreq = 2'b00;
        tick(); tick();

        // Reset while a transaction is outstanding.
        mreq[0] = 1'b1;
        tick();
        mrd[0] = 1'b1; pgnt = 1'b1;
        tick();
        mrd[0] = 1'b0; pgnt = 1'b0; mreq[0] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0; pready = 1'b1; pspo = 32'hCAFE_F00D; #1;
        chk("rstbusy_ready", {30'd0, rdy}, 32'd0);
        chk("rstbusy_gnt", {30'd0, gnt}, 32'd0);
        chk("rstbusy_err", {31'd0, err}, 32'd0);
        tick();
        pready = 1'b0;

        // Random traffic against the reference.
        for (int c = 0; c < 800; c++) begin
            rst    = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 2; i++) begin
                mreq[i] = ($urandom_range(0, 3) != 0);
                mwe[i]  = ($urandom_range(0, 4) == 0);
                mrd[i]  = ($urandom_range(0, 4) == 0);
                ma[i]   = $urandom;
                md[i]   = $urandom;
            end
            pgnt   = ($urandom_range(0, 3) != 0);
            phrd   = ($urandom_range(0, 7) == 0);
            pready = ($urandom_range(0, 5) == 0);
            pspo   = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
